// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage store buffer path.
// The store_buffer build option STORE_BUFFER_FWD_EN does not change anything here.
package mem_pkg;

  localparam int unsigned AW_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT = 16;

  typedef struct packed {
    logic [AW_DEFAULT-1:0] addr;
    logic [DW_DEFAULT-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular {addr, data} storage for store_buffer. With STORE_BUFFER_FWD_EN
// defined, it also exposes a youngest-match lookup over the valid entries.
module store_buffer_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
`ifdef STORE_BUFFER_FWD_EN
  ,
  input  logic [AW-1:0] match_addr,
  output logic          match_hit,
  output logic [DW-1:0] match_data
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          empty_q, empty_d;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = empty_q;

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[idx] == match_addr)) begin
        match_hit  = 1'b1;
        match_data = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM and data_memory; loads take the port first.
// Define STORE_BUFFER_FWD_EN to let loads forward from buffered stores.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  input  logic          drain_hold,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          empty,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_store_data,
  input  logic [DW-1:0] mem_load_data,
  output logic          mem_read,
  output logic          mem_write
);

  logic          full;
  logic          load_ready;
  logic          load_acc;
  logic          store_acc;
  logic          drain;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [DW-1:0] load_data;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;

`ifdef STORE_BUFFER_FWD_EN
  logic          match_hit;
  logic [DW-1:0] match_data;

  assign load_ready = 1'b1;
  assign load_data  = match_hit ? match_data : mem_load_data;
`else
  // Without forwarding a load must wait until memory holds every store.
  assign load_ready = empty;
  assign load_data  = mem_load_data;
`endif

  store_buffer_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (store_acc),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .pop        (drain),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
`ifdef STORE_BUFFER_FWD_EN
    ,
    .match_addr (req_addr),
    .match_hit  (match_hit),
    .match_data (match_data)
`endif
  );

  // rst_n gating keeps both memory strobes low while reset is held.
  always_comb begin
    req_ready      = req_write ? ~full : load_ready;
    load_acc       = rst_n & req_valid & ~req_write & load_ready;
    store_acc      = rst_n & req_valid & req_write & ~full;
    drain          = rst_n & ~load_acc & ~drain_hold & ~empty;
    mem_read       = load_acc;
    mem_write      = drain;
    mem_address    = '0;
    mem_store_data = '0;
    if (load_acc) begin
      mem_address = req_addr;
    end else if (drain) begin
      mem_address    = head_addr;
      mem_store_data = head_data;
    end
    resp_valid_d = load_acc;
    resp_rdata_d = load_acc ? load_data : resp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
// Works with or without STORE_BUFFER_FWD_EN.
module tb_store_buffer;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          drain_hold = 1'b0;
  logic          req_ready, resp_valid, empty, mem_read, mem_write;
  logic [DW-1:0] resp_rdata, mem_store_data, mem_load_data;
  logic [AW-1:0] mem_address;

  logic [DW-1:0] dmem    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  sb_entry_t     q[$];

  int checks = 0;
  int errors = 0;

  logic          exp_ready, exp_lacc, exp_sacc, exp_drain, exp_empty;
  logic          exp_resp_valid = 1'b0;
  logic [DW-1:0] exp_resp_rdata = '0;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_sdata, exp_load_val;

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .drain_hold     (drain_hold),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .empty          (empty),
    .mem_address    (mem_address),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  always #5 clk = ~clk;

  assign mem_load_data = dmem[mem_address];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_address] <= mem_store_data;
  end

  // Expected combinational outputs for the request currently on the port.
  task automatic predict();
    bit is_full, is_empty, lrdy;
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
`ifdef STORE_BUFFER_FWD_EN
    lrdy = 1'b1;
`else
    lrdy = is_empty;
`endif
    exp_empty = is_empty;
    exp_ready = req_write ? !is_full : lrdy;
    exp_lacc  = req_valid && !req_write && lrdy;
    exp_sacc  = req_valid && req_write && !is_full;
    exp_drain = !exp_lacc && !drain_hold && !is_empty;
    exp_addr  = '0;
    exp_sdata = '0;
    if (exp_lacc) exp_addr = req_addr;
    else if (exp_drain) begin
      exp_addr  = q[0].addr;
      exp_sdata = q[0].data;
    end
    exp_load_val = ref_mem[req_addr];
`ifdef STORE_BUFFER_FWD_EN
    foreach (q[i]) if (q[i].addr == req_addr) exp_load_val = q[i].data;
`endif
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic h);
    @(negedge clk);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    drain_hold = h;
    #1;
    predict();
  endtask

  task automatic advance();
    sb_entry_t e;
    @(posedge clk);
    if (exp_drain) begin
      ref_mem[q[0].addr] = q[0].data;
      void'(q.pop_front());
    end
    if (exp_sacc) begin
      e.addr = req_addr;
      e.data = req_wdata;
      q.push_back(e);
    end
    exp_resp_valid = exp_lacc;
    if (exp_lacc) exp_resp_rdata = exp_load_val;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, '0, '0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_store_ready: got %b want 1", req_ready); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== '0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0000", resp_rdata); end
    advance();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", req_ready); end
    advance();
  endtask

  task automatic test_single_store();
    drive(1'b1, 1'b1, 16'd1, 16'h000F, 1'b0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req_ready); end
    advance();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL single_write: got %b want 1", mem_write); end
    checks++; if (mem_address !== 16'd1) begin errors++; $display("FAIL single_addr: got %h want 0001", mem_address); end
    checks++; if (mem_store_data !== 16'h000F) begin errors++; $display("FAIL single_data: got %h want 000f", mem_store_data); end
    advance();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
    advance();
    drive(1'b1, 1'b0, 16'd1, '0, 1'b0);
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL single_load_read: got %b want 1", mem_read); end
    advance();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 16'h000F) begin errors++; $display("FAIL single_resp_rdata: got %h want 000f", resp_rdata); end
    advance();
  endtask

  task automatic test_fill_full();
    for (int a = 2; a <= 5; a++) begin
      drive(1'b1, 1'b1, AW'(a), DW'(16'hA0 + a), 1'b1);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", a, req_ready); end
      advance();
    end
    drive(1'b1, 1'b1, 16'd6, 16'h00A6, 1'b1);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL drain_write_%0d: got %b want 1", k, mem_write); end
      checks++; if (mem_address !== AW'(k + 2)) begin errors++; $display("FAIL drain_addr_%0d: got %h want %h", k, mem_address, AW'(k + 2)); end
      checks++; if (mem_store_data !== DW'(16'hA2 + k)) begin errors++; $display("FAIL drain_data_%0d: got %h want %h", k, mem_store_data, DW'(16'hA2 + k)); end
      advance();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained_empty: got %b want 1", empty); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL fill_drained_write: got %b want 0", mem_write); end
    advance();
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b1, 16'd8, 16'h0808, 1'b1); advance();
    drive(1'b1, 1'b1, 16'd9, 16'h0909, 1'b1); advance();
`ifdef STORE_BUFFER_FWD_EN
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, AW'(k + 7), '0, 1'b0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_%0d: got %b want 1", k, req_ready); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL prio_no_write_%0d: got %b want 0", k, mem_write); end
      if (k > 0) begin
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL prio_resp_valid_%0d: got %b want 1", k, resp_valid); end
        checks++; if (resp_rdata !== exp_resp_rdata) begin errors++; $display("FAIL prio_resp_rdata_%0d: got %h want %h", k, resp_rdata, exp_resp_rdata); end
      end
      advance();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL prio_resp_valid_last: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 16'h0909) begin errors++; $display("FAIL prio_fwd_rdata: got %h want 0909", resp_rdata); end
    checks++; if (mem_write !== 1'b1 || mem_address !== 16'd8) begin errors++; $display("FAIL prio_resume: got write %b addr %h want 1 0008", mem_write, mem_address); end
    advance();
`else
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 16'd8, '0, 1'b0);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL prio_stall_%0d: got %b want 0", k, req_ready); end
      checks++; if (mem_write !== 1'b1 || mem_address !== AW'(k + 8)) begin errors++; $display("FAIL prio_drain_%0d: got write %b addr %h want 1 %h", k, mem_write, mem_address, AW'(k + 8)); end
      advance();
    end
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, AW'(k + 8), '0, 1'b0);
      if (k > 0) begin
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_resp_rdata) begin errors++; $display("FAIL b2b_resp_%0d: got %b %h want 1 %h", k, resp_valid, resp_rdata, exp_resp_rdata); end
      end
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++; if (mem_write !== exp_drain || mem_address !== exp_addr) begin errors++; $display("FAIL prio_tail_%0d: got %b %h want %b %h", k, mem_write, mem_address, exp_drain, exp_addr); end
      advance();
    end
  endtask

  task automatic test_forwarding();
    bit accepted;
    drive(1'b1, 1'b1, 16'd7, 16'h1111, 1'b1); advance();
    drive(1'b1, 1'b1, 16'd7, 16'h2222, 1'b1); advance();
`ifdef STORE_BUFFER_FWD_EN
    drive(1'b1, 1'b0, 16'd7, '0, 1'b1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready: got %b want 1", req_ready); end
    advance();
`else
    drive(1'b1, 1'b0, 16'd7, '0, 1'b1);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fwd_stall_hold: got %b want 0", req_ready); end
    advance();
    accepted = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) begin
      drive(1'b1, 1'b0, 16'd7, '0, 1'b0);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL fwd_stall_%0d: got %b want %b", n, req_ready, exp_ready); end
      accepted = exp_lacc;
      advance();
    end
    checks++; if (!accepted) begin errors++; $display("FAIL fwd_stall_timeout: got 0 want 1"); end
`endif
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL fwd_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 16'h2222) begin errors++; $display("FAIL fwd_resp_rdata: got %h want 2222", resp_rdata); end
    advance();
    for (int k = 0; k < 3; k++) begin drive(1'b0, 1'b0, '0, '0, 1'b0); advance(); end
    checks++; if (dmem[7] !== 16'h2222) begin errors++; $display("FAIL fwd_mem7: got %h want 2222", dmem[7]); end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b1, AW'(16'h20 + k), DW'(16'h5A00 + k), 1'b1); advance(); end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (mem_write !== 1'b1 || mem_address !== 16'h0020) begin errors++; $display("FAIL mid_drain_write: got %b %h want 1 0020", mem_write, mem_address); end
    advance();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    exp_resp_valid = 1'b0;
    exp_resp_rdata = '0;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write: got %b want 0", mem_write); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_resp: got %b want 0", resp_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, '0, '0, 1'b0);
      checks++; if (mem_write !== 1'b0 || req_ready !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL rst_after_%0d: got write %b ready %b empty %b want 0 1 1", k, mem_write, req_ready, empty); end
      advance();
    end
    checks++; if (dmem[16'h21] !== ref_mem[16'h21] || dmem[16'h22] !== ref_mem[16'h22]) begin errors++; $display("FAIL rst_discard: got %h %h want %h %h", dmem[16'h21], dmem[16'h22], ref_mem[16'h21], ref_mem[16'h22]); end
  endtask

  task automatic test_random();
    logic v, w, h;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) != 0;
      h = ($urandom_range(0, 3) == 0);
      drive(v, w, AW'($urandom_range(0, 15)), DW'($urandom), h);
      checks++;
      if (req_ready !== exp_ready || mem_read !== exp_lacc || mem_write !== exp_drain ||
          mem_address !== exp_addr || mem_store_data !== exp_sdata || empty !== exp_empty ||
          resp_valid !== exp_resp_valid || resp_rdata !== exp_resp_rdata) begin
        errors++;
        $display("FAIL rand_%0d: got rdy %b rd %b wr %b a %h d %h e %b rv %b rd %h want %b %b %b %h %h %b %b %h",
                 n, req_ready, mem_read, mem_write, mem_address, mem_store_data, empty, resp_valid, resp_rdata,
                 exp_ready, exp_lacc, exp_drain, exp_addr, exp_sdata, exp_empty, exp_resp_valid, exp_resp_rdata);
      end
      advance();
    end
    for (int k = 0; k < DEPTH + 2; k++) begin drive(1'b0, 1'b0, '0, '0, 1'b0); advance(); end
    for (int a = 0; a < 16; a++) begin
      checks++; if (dmem[a] !== ref_mem[a]) begin errors++; $display("FAIL rand_mem_%0d: got %h want %h", a, dmem[a], ref_mem[a]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_store();
    test_fill_full();
    test_load_priority();
    test_forwarding();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM pipeline stage and `data_memory`. Stores are queued and retired to memory in the background; loads bypass the queue and get priority on the memory port. The block presents a single request port to the pipeline and drives `data_memory`'s address, store-data, read and write strobes directly. It returns load data one cycle after acceptance.

## Interface
- `DEPTH`, 4: number of buffered stores, a power of two, minimum 2.
- `AW`, 16: address width.
- `DW`, 16: data width.

- `clk`  in  1  system clock, all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline request present.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  AW  request word address.
- `req_wdata`  in  DW  store data.
- `req_ready`  out  1  request is accepted at this edge if `req_valid` is also high.
- `drain_hold`  in  1  inhibits retirement of buffered stores (debug/DMA).
- `resp_valid`  out  1  load data valid, one-cycle pulse.
- `resp_rdata`  out  DW  load data.
- `empty`  out  1  no buffered stores.
- `mem_address`  out  AW  to `data_memory` address.
- `mem_store_data`  out  DW  to `data_memory` store data.
- `mem_load_data`  in  DW  from `data_memory`; combinational read.
- `mem_read`  out  1  `data_memory` read strobe.
- `mem_write`  out  1  `data_memory` write strobe; the write occurs at the rising edge.

## Operation
- The state is a circular FIFO of {addr, data} entries with head pointer, tail pointer and count.
- Reset values: count 0, pointers 0, `empty`=1, `resp_valid`=0, `resp_rdata`=0.
  - Memory strobes are 0 while reset is asserted.
  - Reset mid-operation discards buffered stores without writing them.
- **Store accept:** `req_ready`=(count<DEPTH) and the entry goes to the tail. There is no response.
  - Stores are not coalesced; duplicate addresses occupy separate entries.
- **Load accept** (`req_ready` rule depends on the Configuration macro):
  - `mem_read`=1 and `mem_address`=`req_addr` in the same cycle.
  - Data is registered into `resp_rdata`.
- **Drain:** in any cycle with no load accepted, `drain_hold`=0 and count>0:
  - `mem_write`=1, and the address and data come from the head entry.
  - The head is popped at that edge.
- **Port priority:** an accepted load beats drain. At most one memory access happens per cycle.
- **Simultaneous events:**
  - Store accept and drain pop in the same cycle leave the count unchanged.
  - When full, `req_ready` for stores stays 0 even if a pop occurs that cycle; there is no same-cycle bypass.
- Both pointers wrap modulo DEPTH.
- When idle, `mem_address`/`mem_store_data` drive 0.

## Timing
- Request in cycle c with ready high: accepted at the edge ending c.
- Load: `resp_valid`=1 during cycle c+1 only, with `resp_rdata` valid. Latency is 1, and a new load may be accepted every cycle.
- Store: the earliest `mem_write` for it is cycle c+1, and memory is updated at the edge ending c+1.
- `empty` is registered and reflects the count after each edge.

## Configuration
- `STORE_BUFFER_FWD_EN` defined:
  - Loads are always ready.
  - The load address is compared against all valid entries. On a match, the youngest matching entry's data is returned and `mem_read` is still asserted, but memory data is ignored.
  - With no match, memory data is returned.
- Undefined:
  - There are no comparators.
  - Load `req_ready`=`empty`, so loads stall until the buffer has fully drained and then read memory.

## Structure
- Shared package `mem_pkg`: `AW`/`DW` defaults and the typedef `sb_entry_t` {addr, data}.
- One sub-module, `store_buffer_fifo`: the circular storage, pointers, count, push/pop, and a youngest-match search port under the macro.
- The top handles the request decode, port arbitration, the response register and the memory-side muxing.

## Test plan
- **Reset:** assert `rst_n`=0 mid-drain, then release. Required: `empty`=1, `req_ready`=1, `mem_write`=0, `resp_valid`=0, and no pending write ever occurs.
- **Single store then drain:** store addr 1, data 0x000F with `drain_hold`=0. Required:
  - Next cycle: `mem_write`=1, `mem_address`=1, `mem_store_data`=0x000F.
  - `empty`=1 after that edge.
  - A later load of addr 1 returns 0x000F.
- **Fill and full:** with `drain_hold`=1, store addrs 2,3,4,5. Required:
  - `req_ready`=0 on the fifth store.
  - Release hold: four writes come out in order 2,3,4,5 on consecutive cycles, then `empty`=1.
- **Load priority:** with 2 entries buffered, issue 3 back-to-back loads. Required:
  - `mem_write`=0 during those 3 cycles.
  - `resp_valid` is high on 3 consecutive cycles.
  - Draining resumes afterwards.
- **Forwarding (macro defined):** with hold set, store addr 7 data 0x1111, then addr 7 data 0x2222, then load addr 7. Required: `resp_rdata`=0x2222.
- **Forwarding (macro undefined):** same sequence. Required:
  - The load stalls (`req_ready`=0) until the buffer drains.
  - It then returns 0x2222 from memory.
